// File: rtl/mem_port_arbiter_if.sv
// Shared-memory-port bundle between the hart requesters, the arbiter and the memory.
// The package carries the store width type used by both requester and memory sides.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    write_byte = 2'd0,
    write_half = 2'd1,
    write_word = 2'd2
  } write_width_t;
endpackage

interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  import mem_port_arbiter_pkg::*;

  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_r_valid;
  logic [XLEN-1:0] if_r_data;

  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_w_data;
  write_width_t    d_w_width;
  logic            d_gnt;
  logic            d_done;
  logic [XLEN-1:0] d_r_data;

  logic [XLEN-1:0] mem_addr;
  logic            mem_w_enable;
  logic [XLEN-1:0] mem_w_data;
  write_width_t    mem_w_width;
  logic [XLEN-1:0] mem_r_data;
  logic            mmio_write_complete;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_w_data, d_w_width,
           mem_r_data, mmio_write_complete,
    output if_gnt, if_r_valid, if_r_data, d_gnt, d_done, d_r_data,
           mem_addr, mem_w_enable, mem_w_data, mem_w_width
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_w_data, d_w_width,
           mem_r_data, mmio_write_complete,
    input  if_gnt, if_r_valid, if_r_data, d_gnt, d_done, d_r_data,
           mem_addr, mem_w_enable, mem_w_data, mem_w_width
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one synchronous-read memory port between instruction fetch
// and load/store, with a stall on MMIO writes until the device acknowledges them.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] mmio_start_addr = 32'h0003_0000
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RESP, MMIO_WAIT} state_t;
  typedef enum logic {OWNER_IF, OWNER_D} owner_t;

  state_t          state;
  owner_t          last_grant;
  owner_t          resp_owner;
  logic [XLEN-1:0] mmio_addr_p1;

  logic can_grant;
  logic gnt_if;
  logic gnt_d;
  logic d_is_mmio_wr;

  // Grant stage: the winner drives the memory port combinationally this cycle
  always_comb begin
    can_grant    = !reset && (state != MMIO_WAIT);
    gnt_if       = can_grant && bus.if_req && (!bus.d_req || last_grant == OWNER_D);
    gnt_d        = can_grant && bus.d_req && !gnt_if;
    d_is_mmio_wr = bus.d_we && (bus.d_addr >= mmio_start_addr);

    bus.if_gnt       = gnt_if;
    bus.d_gnt        = gnt_d;
    bus.mem_addr     = '0;
    bus.mem_w_enable = 1'b0;
    bus.mem_w_data   = '0;
    bus.mem_w_width  = write_word;
    if (gnt_if) begin
      bus.mem_addr = bus.if_addr;
    end else if (gnt_d) begin
      bus.mem_addr     = bus.d_addr;
      bus.mem_w_enable = bus.d_we;
      bus.mem_w_data   = bus.d_w_data;
      bus.mem_w_width  = bus.d_w_width;
    end else if (!reset && state == MMIO_WAIT) begin
      bus.mem_addr = mmio_addr_p1;
    end
  end

  // Response stage: read data arrives one cycle after its address
  always_comb begin
    bus.if_r_valid = !reset && (state == RESP) && (resp_owner == OWNER_IF);
    bus.d_done     = !reset && (state == RESP) && (resp_owner == OWNER_D);
    bus.if_r_data  = bus.if_r_valid ? bus.mem_r_data : '0;
    bus.d_r_data   = bus.d_done ? bus.mem_r_data : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= OWNER_D;
      resp_owner <= OWNER_D;
    end else begin
      unique case (state)
        IDLE, RESP: begin
          if (gnt_if) begin
            last_grant <= OWNER_IF;
            resp_owner <= OWNER_IF;
            state      <= RESP;
          end else if (gnt_d) begin
            last_grant <= OWNER_D;
            resp_owner <= OWNER_D;
            state      <= d_is_mmio_wr ? MMIO_WAIT : RESP;
          end else begin
            state <= IDLE;
          end
        end
        MMIO_WAIT: begin
          if (bus.mmio_write_complete) begin
            resp_owner <= OWNER_D;
            state      <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The MMIO address stays on the port for the whole wait
  always_ff @(posedge clock) begin
    if (gnt_d) mmio_addr_p1 <= bus.d_addr;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; unwritten memory reads back as the inverted address.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.XLEN(32)) bus ();

  mem_port_arbiter #(.XLEN(32), .mmio_start_addr(32'h0003_0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] rd_word;

  always @(posedge clock) begin
    rd_word = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : ~bus.mem_addr;
    if (bus.mem_w_enable) mem_model[bus.mem_addr] = bus.mem_w_data;
    bus.mem_r_data <= rd_word;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  logic [3:0] exp_if_gnt;
  logic [3:0] exp_d_gnt;
  logic [3:0] exp_if_v;
  logic [3:0] exp_d_done;

  initial begin
    bus.if_req              = 1'b0;
    bus.if_addr             = '0;
    bus.d_req               = 1'b0;
    bus.d_we                = 1'b0;
    bus.d_addr              = '0;
    bus.d_w_data            = '0;
    bus.d_w_width           = write_word;
    bus.mmio_write_complete = 1'b0;

    // reset state
    next_cycle;
    next_cycle;
    reset = 1'b0;
    settle;
    check("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    check("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("rst_if_v", 32'(bus.if_r_valid), 32'd0);
    check("rst_d_done", 32'(bus.d_done), 32'd0);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_wen", 32'(bus.mem_w_enable), 32'd0);
    check("rst_width", 32'(bus.mem_w_width), 32'(write_word));
    check("rst_if_rdata", bus.if_r_data, 32'h0);

    // single fetch
    next_cycle;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0001_0000;
    settle;
    check("f_gnt", 32'(bus.if_gnt), 32'd1);
    check("f_addr", bus.mem_addr, 32'h0001_0000);
    check("f_wen", 32'(bus.mem_w_enable), 32'd0);
    next_cycle;
    bus.if_req = 1'b0;
    settle;
    check("f_valid", 32'(bus.if_r_valid), 32'd1);
    check("f_rdata", bus.if_r_data, 32'hFFFE_FFFF);
    check("f_gnt_off", 32'(bus.if_gnt), 32'd0);

    // contention after a fresh reset
    next_cycle;
    reset = 1'b1;
    next_cycle;
    reset       = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0002_0004;
    exp_if_gnt  = 4'b0101;
    exp_d_gnt   = 4'b1010;
    exp_if_v    = 4'b1010;
    exp_d_done  = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cycle;
      settle;
      check($sformatf("c%0d_if_gnt", c), 32'(bus.if_gnt), 32'(exp_if_gnt[c]));
      check($sformatf("c%0d_d_gnt", c), 32'(bus.d_gnt), 32'(exp_d_gnt[c]));
      check($sformatf("c%0d_if_v", c), 32'(bus.if_r_valid), 32'(exp_if_v[c]));
      check($sformatf("c%0d_d_done", c), 32'(bus.d_done), 32'(exp_d_done[c]));
    end
    check("c3_addr", bus.mem_addr, 32'h0002_0004);
    next_cycle;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    settle;
    check("c4_d_done", 32'(bus.d_done), 32'd1);
    check("c4_d_rdata", bus.d_r_data, 32'hFFFD_FFFB);
    check("c4_addr", bus.mem_addr, 32'h0);

    // RAM store then load
    next_cycle;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 32'h0002_0000;
    bus.d_w_data  = 32'hDEAD_BEEF;
    bus.d_w_width = write_word;
    settle;
    check("st_gnt", 32'(bus.d_gnt), 32'd1);
    check("st_wen", 32'(bus.mem_w_enable), 32'd1);
    check("st_wdata", bus.mem_w_data, 32'hDEAD_BEEF);
    check("st_addr", bus.mem_addr, 32'h0002_0000);
    next_cycle;
    bus.d_we = 1'b0;
    settle;
    check("st_done", 32'(bus.d_done), 32'd1);
    check("ld_gnt", 32'(bus.d_gnt), 32'd1);
    check("ld_wen", 32'(bus.mem_w_enable), 32'd0);
    next_cycle;
    bus.d_req = 1'b0;
    settle;
    check("ld_done", 32'(bus.d_done), 32'd1);
    check("ld_rdata", bus.d_r_data, 32'hDEAD_BEEF);

    // MMIO store with completion five cycles after grant
    next_cycle;
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b1;
    bus.d_addr   = 32'h0003_0000;
    bus.d_w_data = 32'h1234_5678;
    settle;
    check("mm_gnt", 32'(bus.d_gnt), 32'd1);
    check("mm_wen", 32'(bus.mem_w_enable), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle;
      bus.d_req   = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0000_0200;
      settle;
      check($sformatf("mw%0d_if_gnt", k), 32'(bus.if_gnt), 32'd0);
      check($sformatf("mw%0d_wen", k), 32'(bus.mem_w_enable), 32'd0);
      check($sformatf("mw%0d_addr", k), bus.mem_addr, 32'h0003_0000);
      check($sformatf("mw%0d_done", k), 32'(bus.d_done), 32'd0);
    end
    next_cycle;
    bus.mmio_write_complete = 1'b1;
    settle;
    check("mw5_if_gnt", 32'(bus.if_gnt), 32'd0);
    check("mw5_done", 32'(bus.d_done), 32'd0);
    next_cycle;
    bus.mmio_write_complete = 1'b0;
    settle;
    check("mm_done", 32'(bus.d_done), 32'd1);
    check("mm_if_gnt", 32'(bus.if_gnt), 32'd1);
    check("mm_if_addr", bus.mem_addr, 32'h0000_0200);
    next_cycle;
    bus.if_req              = 1'b0;
    bus.mmio_write_complete = 1'b1;
    settle;
    check("mm_if_v", 32'(bus.if_r_valid), 32'd1);
    check("mm_if_rdata", bus.if_r_data, 32'hFFFF_FDFF);
    check("mm_no_done", 32'(bus.d_done), 32'd0);
    next_cycle;
    bus.mmio_write_complete = 1'b0;
    settle;
    check("mm_stray_done", 32'(bus.d_done), 32'd0);
    check("mm_stray_v", 32'(bus.if_r_valid), 32'd0);

    // reset while waiting on an MMIO write
    next_cycle;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b1;
    bus.d_addr = 32'h0003_0010;
    settle;
    check("rm_gnt", 32'(bus.d_gnt), 32'd1);
    next_cycle;
    bus.d_req = 1'b0;
    reset     = 1'b1;
    settle;
    check("rm_rst_done", 32'(bus.d_done), 32'd0);
    check("rm_rst_addr", bus.mem_addr, 32'h0);
    next_cycle;
    reset                   = 1'b0;
    bus.if_req              = 1'b1;
    bus.if_addr             = 32'h0000_0300;
    bus.d_req               = 1'b1;
    bus.d_we                = 1'b0;
    bus.d_addr              = 32'h0002_0000;
    bus.mmio_write_complete = 1'b1;
    settle;
    check("rm_done", 32'(bus.d_done), 32'd0);
    check("rm_if_gnt", 32'(bus.if_gnt), 32'd1);
    check("rm_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("rm_addr", bus.mem_addr, 32'h0000_0300);
    next_cycle;
    bus.if_req              = 1'b0;
    bus.mmio_write_complete = 1'b0;
    settle;
    check("rm_d_gnt2", 32'(bus.d_gnt), 32'd1);
    check("rm_if_v", 32'(bus.if_r_valid), 32'd1);
    check("rm_done2", 32'(bus.d_done), 32'd0);
    next_cycle;
    bus.d_req = 1'b0;
    settle;
    check("rm_ld_done", 32'(bus.d_done), 32'd1);
    check("rm_ld_rdata", bus.d_r_data, 32'hDEAD_BEEF);

    // idle bus
    for (int k = 0; k < 10; k++) begin
      next_cycle;
      settle;
      check($sformatf("idle%0d_wen", k), 32'(bus.mem_w_enable), 32'd0);
      check($sformatf("idle%0d_addr", k), bus.mem_addr, 32'h0);
      check($sformatf("idle%0d_resp", k), 32'(bus.if_r_valid | bus.d_done), 32'd0);
      check($sformatf("idle%0d_width", k), 32'(bus.mem_w_width), 32'(write_word));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
